// File: rtl/decoder2x4_seq_if.sv
// Bundle of the decoder's control inputs and decoded outputs.
// The master drives the code/strobes; the slave (the decoder) returns the results.
interface decoder2x4_seq_if;
  logic       enable;
  logic [1:0] r;
  logic       valid;
  logic       scan;
  logic [3:0] y;
  logic [1:0] code;
  logic       busy;
  logic [9:0] LEDR;

  modport master (
    output enable, r, valid, scan,
    input  y, code, busy, LEDR
  );

  modport slave (
    input  enable, r, valid, scan,
    output y, code, busy, LEDR
  );
endinterface

// File: rtl/decoder2x4_seq.sv
// Registered 2-to-4 one-hot decoder.
// A valid code is shown for HOLD cycles; otherwise an optional scan walks the four outputs.
module decoder2x4_seq #(
  parameter int HOLD = 8,
  parameter int DIV  = 4
) (
  input logic              clk,
  input logic              reset,
  decoder2x4_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_SCAN = 2'd2
  } state_t;

  // Counters are preloaded with (length - 1) and count down to zero.
  localparam logic [7:0] HOLD_M1 = 8'(HOLD - 1);
  localparam logic [7:0] DIV_M1  = 8'(DIV - 1);

  state_t     state_q, state_d;
  logic [3:0] y_q, y_d;
  logic [1:0] code_q, code_d;
  logic       busy_q, busy_d;
  logic [1:0] idx_q, idx_d;
  logic [7:0] holdCnt_q, holdCnt_d;
  logic [7:0] divCnt_q, divCnt_d;
  logic [1:0] idxNext;

  function automatic logic [3:0] onehot(input logic [1:0] c);
    return 4'b0001 << c;
  endfunction

  assign idxNext = idx_q + 2'd1;

  always_comb begin
    state_d   = state_q;
    y_d       = y_q;
    code_d    = code_q;
    busy_d    = busy_q;
    idx_d     = idx_q;
    holdCnt_d = holdCnt_q;
    divCnt_d  = divCnt_q;

    unique case (state_q)
      ST_IDLE: begin
        y_d    = 4'b0000;
        busy_d = 1'b0;
        if (bus.valid) begin
          state_d   = ST_HOLD;
          code_d    = bus.r;
          y_d       = onehot(bus.r);
          busy_d    = 1'b1;
          holdCnt_d = HOLD_M1;
        end else if (bus.scan) begin
          state_d  = ST_SCAN;
          idx_d    = 2'd0;
          y_d      = onehot(2'd0);
          busy_d   = 1'b1;
          divCnt_d = DIV_M1;
        end
      end

      ST_HOLD: begin
        if (holdCnt_q == 8'd0) begin
          state_d = ST_IDLE;
          y_d     = 4'b0000;
          busy_d  = 1'b0;
        end else begin
          holdCnt_d = holdCnt_q - 8'd1;
        end
      end

      ST_SCAN: begin
        // A fresh code preempts the scan even if scan drops on the same edge.
        if (bus.valid) begin
          state_d   = ST_HOLD;
          code_d    = bus.r;
          y_d       = onehot(bus.r);
          holdCnt_d = HOLD_M1;
          idx_d     = 2'd0;
          divCnt_d  = 8'd0;
        end else if (!bus.scan) begin
          state_d  = ST_IDLE;
          y_d      = 4'b0000;
          busy_d   = 1'b0;
          idx_d    = 2'd0;
          divCnt_d = 8'd0;
        end else if (divCnt_q == 8'd0) begin
          idx_d    = idxNext;
          y_d      = onehot(idxNext);
          divCnt_d = DIV_M1;
        end else begin
          divCnt_d = divCnt_q - 8'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        y_d     = 4'b0000;
        busy_d  = 1'b0;
      end
    endcase

    // Disabling wins over everything above but keeps the last code.
    if (!bus.enable) begin
      state_d   = ST_IDLE;
      y_d       = 4'b0000;
      busy_d    = 1'b0;
      idx_d     = 2'd0;
      holdCnt_d = 8'd0;
      divCnt_d  = 8'd0;
      code_d    = code_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      y_q       <= 4'b0000;
      code_q    <= 2'b00;
      busy_q    <= 1'b0;
      idx_q     <= 2'd0;
      holdCnt_q <= 8'd0;
      divCnt_q  <= 8'd0;
    end else begin
      state_q   <= state_d;
      y_q       <= y_d;
      code_q    <= code_d;
      busy_q    <= busy_d;
      idx_q     <= idx_d;
      holdCnt_q <= holdCnt_d;
      divCnt_q  <= divCnt_d;
    end
  end

  assign bus.y    = y_q;
  assign bus.code = code_q;
  assign bus.busy = busy_q;
  assign bus.LEDR = {3'b000, busy_q, code_q, y_q};

endmodule

// File: doc/decoder2x4_seq.md
DECODER2X4_SEQ -- requirements
Module: decoder2x4_seq

Interface
REQ-001 SHALL provide parameter HOLD, default 8, meaning the number of cycles a decoded one-hot output is held (legal range 1-255).
REQ-002 SHALL provide parameter DIV, default 4, meaning the number of cycles per scan step (legal range 1-255).
REQ-003 SHALL provide port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL provide port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL provide port enable  input  1  active-high block enable; low forces the idle condition.
REQ-006 SHALL provide port r  input  2  binary code to decode, same encoding as the team's 2-bit encoder output.
REQ-007 SHALL provide port valid  input  1  code-valid strobe; r is sampled only when valid is high.
REQ-008 SHALL provide port scan  input  1  request for the auto-walking one-hot scan mode.
REQ-009 SHALL provide port y  output  4  registered one-hot (or all-zero) decoded output.
REQ-010 SHALL provide port code  output  2  last latched code.
REQ-011 SHALL provide port busy  output  1  high in HOLD and SCAN states.
REQ-012 SHALL provide port LEDR  output  10  LEDR[3:0]=y, LEDR[5:4]=code, LEDR[6]=busy, LEDR[9:7]=0.
REQ-013 The interface SHALL have exactly one clock; reset SHALL be synchronous and active-high.

Function
REQ-014 All outputs SHALL be registered or direct copies of registers; no combinational path from inputs to y, code or busy.
REQ-015 The FSM SHALL have three states: IDLE, HOLD, SCAN.
REQ-016 Onehot mapping SHALL be: 00->0001, 01->0010, 10->0100, 11->1000.
REQ-017 In IDLE, y SHALL be 0000 and busy 0.
REQ-018 In IDLE with enable=1 and valid=1 at edge N, code SHALL load r, state SHALL go HOLD, and y SHALL equal onehot(r) after edge N (latency 1 cycle).
REQ-019 In IDLE with enable=1, valid=0 and scan=1, state SHALL go SCAN with scan index 0 (y=0001) after the edge.
REQ-020 valid SHALL take priority over scan when both are high.
REQ-021 In HOLD, y SHALL equal onehot(code) for exactly HOLD consecutive cycles, then return to 0000 with state IDLE.
REQ-022 In HOLD, valid and scan SHALL be ignored; code SHALL NOT reload until HOLD completes.
REQ-023 In SCAN, y SHALL equal onehot(index) and SHALL advance once every DIV cycles; index wraps 3->0.
REQ-024 In SCAN, scan=0 at an edge SHALL return the block to IDLE (y=0000) after that edge; index SHALL reset to 0 on the next SCAN entry.
REQ-025 In SCAN, valid=1 SHALL abort the scan: code loads r and state goes HOLD with a full HOLD count, same edge.
REQ-026 enable=0 at any edge SHALL force IDLE, y=0000, busy=0 after that edge; code SHALL retain its value.
REQ-027 Internal hold and divider counters SHALL be 8 bits wide and SHALL NOT underflow or wrap outside the stated behaviour.
REQ-028 Back-to-back: valid high on the cycle HOLD expires (state IDLE) SHALL be accepted normally; there SHALL be no dead cycles beyond the return to IDLE.

Reset
REQ-029 reset=1 at an edge SHALL set state IDLE, y=0000, code=00, busy=0, scan index 0, and all counters to 0.
REQ-030 reset SHALL take priority over enable, valid and scan, including mid-HOLD and mid-SCAN.
REQ-031 The first edge with reset=0 SHALL evaluate the inputs per IDLE rules.

Verification
REQ-032 Decode: HOLD=8; enable=1, r=10, valid pulse 1 cycle -> y=0100 for exactly 8 cycles, code=10, busy=1 during the hold, then y=0000, busy=0.
REQ-033 Scan wrap: DIV=4; scan held high for 20 cycles -> y sequence 0001,0010,0100,1000,0001, each held 4 cycles; scan low -> y=0000 the next cycle.
REQ-034 Priority/abort: valid=1, r=11 with scan=1 in IDLE -> HOLD with y=1000; valid=1, r=01 mid-SCAN -> y=0010 for HOLD cycles.
REQ-035 Ignore-in-hold: r=00 is loaded; then valid with r=11 during the hold -> y stays 0001 and code stays 00 until expiry.
REQ-036 Disable/reset mid-operation: enable=0 mid-HOLD -> y=0000 next cycle with code kept; reset=1 mid-SCAN -> y=0000, code=00, busy=0 next cycle.
REQ-037 LEDR mapping: in HOLD with code=01 -> LEDR=0001010010; LEDR[9:7]=000 always.
